// File: rtl/elevator_if.sv
// Request/status bundle between the button encoder, motor/door logic and the cabin controller.
// The controller takes the slave view; the encoder/motor side takes the master view.
interface elevator_if;
  logic [2:0] n_stage;
  logic       estop;
  logic [1:0] current_floor;
  logic       moving_up;
  logic       moving_down;
  logic       door_open;
  logic [3:0] pending;

  modport master (
    output n_stage,
    output estop,
    input  current_floor,
    input  moving_up,
    input  moving_down,
    input  door_open,
    input  pending
  );

  modport slave (
    input  n_stage,
    input  estop,
    output current_floor,
    output moving_up,
    output moving_down,
    output door_open,
    output pending
  );
endinterface

// File: rtl/elevator_controller.sv
// SCAN-order cabin sequencer for a 4-floor elevator: latches requests, steps one floor per
// TRAVEL_CYCLES and holds the door for DOOR_CYCLES. Optional emergency stop: ELEVATOR_ESTOP_EN.
module elevator_controller #(
  parameter int TRAVEL_CYCLES = 100,
  parameter int DOOR_CYCLES   = 200,
  parameter int TIMER_W       = 32
) (
  input logic       clk,
  input logic       rst,
  elevator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MOVE  = 2'd1,
    S_DOOR  = 2'd2,
    S_ESTOP = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_CYCLES - 1);

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic [1:0]         floor_q, floor_d, next_floor;
  logic [3:0]         pending_q, pending_d, req_vec, pend_set;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               up_q, down_q, door_q, up_d, down_d, door_d;
  logic               req_vld, absorb, stop_req;
  logic [1:0]         req_flr;

`ifdef ELEVATOR_ESTOP_EN
  state_t saved_q, saved_d;
  assign stop_req = bus.estop;
`else
  logic unused_estop;
  assign unused_estop = bus.estop;
  assign stop_req     = 1'b0;
`endif

  // Floors strictly beyond flr in the given direction (up=1 above, up=0 below).
  function automatic logic [3:0] ahead_mask(input logic [1:0] flr, input logic up);
    if (up) return 4'b1110 << flr;
    return (4'b0001 << flr) - 4'd1;
  endfunction

  assign req_vld    = bus.n_stage[2];
  assign req_flr    = bus.n_stage[1:0];
  assign next_floor = (dir_q && floor_q != 2'd3)  ? floor_q + 2'd1 :
                      (!dir_q && floor_q != 2'd0) ? floor_q - 2'd1 : floor_q;
  // A request for the floor the cabin is standing at just (re)opens the door.
  assign absorb     = req_vld && (req_flr == floor_q) &&
                      (state_q == S_IDLE || state_q == S_DOOR) && !stop_req;

  always_comb begin
    req_vec = 4'b0000;
    if (req_vld && !absorb) req_vec[req_flr] = 1'b1;
    pend_set  = pending_q | req_vec;
    state_d   = state_q;
    dir_d     = dir_q;
    floor_d   = floor_q;
    timer_d   = timer_q;
    pending_d = pend_set;
`ifdef ELEVATOR_ESTOP_EN
    saved_d   = saved_q;
    if (state_q == S_ESTOP) begin
      if (!bus.estop) state_d = saved_q;
    end else if (bus.estop) begin
      state_d = S_ESTOP;
      saved_d = state_q;
    end else
`endif
    begin
      case (state_q)
        S_IDLE: begin
          timer_d = '0;
          if (absorb) begin
            state_d = S_DOOR;
          end else if (pending_q[floor_q]) begin
            pending_d[floor_q] = 1'b0;
            state_d            = S_DOOR;
          end else if (pending_q != 4'b0000) begin
            if ((pending_q & ahead_mask(floor_q, dir_q)) == 4'b0000) dir_d = ~dir_q;
            state_d = S_MOVE;
          end
        end
        S_MOVE: begin
          if (timer_q == TRAVEL_LAST) begin
            timer_d = '0;
            floor_d = next_floor;
            if (pend_set[next_floor]) begin
              pending_d[next_floor] = 1'b0;
              state_d               = S_DOOR;
            end else if ((pend_set & ahead_mask(next_floor, dir_q)) == 4'b0000) begin
              state_d = S_IDLE;
            end
            if (next_floor == 2'd3)      dir_d = 1'b0;
            else if (next_floor == 2'd0) dir_d = 1'b1;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        S_DOOR: begin
          if (absorb) begin
            timer_d = '0;
          end else if (timer_q == DOOR_LAST) begin
            timer_d = '0;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    up_d   = (state_d == S_MOVE) && dir_d;
    down_d = (state_d == S_MOVE) && !dir_d;
    door_d = (state_d == S_DOOR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b1;
      floor_q   <= 2'd0;
      pending_q <= 4'b0000;
      timer_q   <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      door_q    <= 1'b0;
`ifdef ELEVATOR_ESTOP_EN
      saved_q   <= S_IDLE;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      up_q      <= up_d;
      down_q    <= down_d;
      door_q    <= door_d;
`ifdef ELEVATOR_ESTOP_EN
      saved_q   <= saved_d;
`endif
    end
  end

  assign bus.current_floor = floor_q;
  assign bus.moving_up     = up_q;
  assign bus.moving_down   = down_q;
  assign bus.door_open     = door_q;
  assign bus.pending       = pending_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller with TRAVEL_CYCLES=4, DOOR_CYCLES=3: vector table, directed
// SCAN/estop sequences, then random requests against a countdown-based cabin model.
module tb_elevator_controller;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  logic clk = 1'b0;
  logic rst;
  elevator_if bus();

  elevator_controller #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR), .TIMER_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [2:0] ns;
    logic [8:0] exp;
  } vec_t;
  vec_t vecs[$];

  // Cabin model: position, direction, request set and countdowns of the current leg/door.
  int       m_floor, m_dir, m_travel, m_door;
  bit [3:0] m_pend;
  bit       m_frozen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] obs();
    return {bus.current_floor, bus.moving_up, bus.moving_down, bus.door_open, bus.pending};
  endfunction

  task automatic check9(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got floor=%0d up=%b dn=%b door=%b pend=%b, expected floor=%0d up=%b dn=%b door=%b pend=%b @%0t",
               name, act[8:7], act[6], act[5], act[4], act[3:0],
               exp[8:7], exp[6], exp[5], exp[4], exp[3:0], $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic r, input logic [2:0] ns, input logic [1:0] fl,
                              input logic up, input logic dn, input logic dr, input logic [3:0] pd);
    vec_t v;
    v.rst = r;
    v.ns  = ns;
    v.exp = {fl, up, dn, dr, pd};
    vecs.push_back(v);
  endfunction

  function automatic bit any_ahead(input bit [3:0] p, input int fl, input int d);
    for (int i = 0; i < 4; i++)
      if (p[i] && ((d > 0 && i > fl) || (d < 0 && i < fl))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic r, input logic [2:0] ns, input logic es);
    bit [3:0] old;
    bit       vld, absorb, stopping;
    int       f;
    if (r) begin
      m_floor = 0; m_dir = 1; m_travel = 0; m_door = 0; m_pend = 4'b0000; m_frozen = 1'b0;
      return;
    end
    vld      = ns[2];
    f        = int'(ns[1:0]);
    old      = m_pend;
    stopping = 1'b0;
`ifdef ELEVATOR_ESTOP_EN
    stopping = es || m_frozen;
`endif
    absorb = vld && (f == m_floor) && (m_travel == 0) && !stopping;
    if (vld && !absorb) m_pend[f] = 1'b1;
`ifdef ELEVATOR_ESTOP_EN
    if (m_frozen) begin
      if (!es) m_frozen = 1'b0;
      return;
    end
    if (es) begin
      m_frozen = 1'b1;
      return;
    end
`endif
    if (m_travel > 0) begin
      if (m_travel == 1) begin
        m_floor  = m_floor + m_dir;
        m_travel = 0;
        if (m_pend[m_floor]) begin
          m_pend[m_floor] = 1'b0;
          m_door          = DOOR;
        end else if (any_ahead(m_pend, m_floor, m_dir)) begin
          m_travel = TRAVEL;
        end
        if (m_floor == 3)      m_dir = -1;
        else if (m_floor == 0) m_dir = 1;
      end else begin
        m_travel--;
      end
    end else if (absorb) begin
      m_door = DOOR;
    end else if (m_door > 0) begin
      m_door--;
    end else if (old[m_floor]) begin
      m_pend[m_floor] = 1'b0;
      m_door          = DOOR;
    end else if (old != 4'b0000) begin
      if (!any_ahead(old, m_floor, m_dir)) m_dir = -m_dir;
      m_travel = TRAVEL;
    end
  endtask

  function automatic logic [8:0] model_obs();
    logic mv;
    mv = !m_frozen && (m_travel > 0);
    return {2'(m_floor), mv && (m_dir > 0), mv && (m_dir < 0), !m_frozen && (m_door > 0), m_pend};
  endfunction

  task automatic wait_door(input int maxc);
    int c = 0;
    while (bus.door_open !== 1'b1 && c < maxc) begin tick(); c++; end
  endtask

  task automatic wait_closed(input int maxc);
    int c = 0;
    while (bus.door_open !== 1'b0 && c < maxc) begin tick(); c++; end
  endtask

  initial begin
    int       c;
    logic     r, es;
    logic [2:0] ns;

    // Reset, run 0 -> 3, same-floor door reload at 3, then reset in the middle of a move.
    add(1'b1, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    add(1'b1, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    add(1'b0, 3'b111, 2'd0, 1'b0, 1'b0, 1'b0, 4'b1000);
    for (int k = 0; k < 12; k++) add(1'b0, 3'b000, 2'(k / 4), 1'b1, 1'b0, 1'b0, 4'b1000);
    for (int k = 0; k < 3; k++)  add(1'b0, 3'b000, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0000);
    add(1'b0, 3'b000, 2'd3, 1'b0, 1'b0, 1'b0, 4'b0000);
    add(1'b0, 3'b111, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0000);
    add(1'b0, 3'b000, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0000);
    add(1'b0, 3'b111, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0000);
    add(1'b0, 3'b000, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0000);
    add(1'b0, 3'b000, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0000);
    add(1'b0, 3'b000, 2'd3, 1'b0, 1'b0, 1'b0, 4'b0000);
    add(1'b0, 3'b100, 2'd3, 1'b0, 1'b0, 1'b0, 4'b0001);
    add(1'b0, 3'b000, 2'd3, 1'b0, 1'b1, 1'b0, 4'b0001);
    add(1'b0, 3'b000, 2'd3, 1'b0, 1'b1, 1'b0, 4'b0001);
    add(1'b1, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    add(1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    rst = 1'b1;
    bus.n_stage = 3'b000;
    bus.estop   = 1'b0;
    foreach (vecs[i]) begin
      rst         = vecs[i].rst;
      bus.n_stage = vecs[i].ns;
      tick();
      check9($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // Intermediate stop: request 1 injected while travelling 0 -> 3.
    bus.n_stage = 3'b111; tick();
    bus.n_stage = 3'b000; tick(); tick();
    bus.n_stage = 3'b101; tick();
    bus.n_stage = 3'b000;
    check9("scan_latch", obs(), {2'd0, 3'b100, 4'b1010});
    wait_door(20);
    check9("scan_stop1", obs(), {2'd1, 3'b001, 4'b1000});
    c = 0;
    while (bus.door_open === 1'b1 && c < 10) begin tick(); c++; end
    checki("scan_door_len", c, DOOR);
    wait_door(30);
    check9("scan_stop3", obs(), {2'd3, 3'b001, 4'b0000});
    wait_closed(10);

    // Request behind the cabin: serve 3 first, then go straight down to 0.
    rst = 1'b1; tick(); rst = 1'b0;
    bus.n_stage = 3'b111; tick();
    bus.n_stage = 3'b000;
    c = 0;
    while (bus.current_floor != 2'd2 && c < 40) begin tick(); c++; end
    bus.n_stage = 3'b100; tick();
    bus.n_stage = 3'b000;
    check9("rev_latch", obs(), {2'd2, 3'b100, 4'b1001});
    wait_door(20);
    check9("rev_stop3", obs(), {2'd3, 3'b001, 4'b0001});
    wait_closed(10);
    wait_door(40);
    check9("rev_stop0", obs(), {2'd0, 3'b001, 4'b0000});
    wait_closed(10);

    // Emergency stop at travel count 2 toward floor 1.
    rst = 1'b1; tick(); rst = 1'b0;
    bus.n_stage = 3'b101; tick();
    bus.n_stage = 3'b000; tick(); tick(); tick();
    bus.estop = 1'b1;
`ifdef ELEVATOR_ESTOP_EN
    for (int k = 0; k < 10; k++) begin
      tick();
      check9($sformatf("estop_hold%0d", k), obs(), {2'd0, 3'b000, 4'b0010});
    end
    bus.estop = 1'b0;
    tick(); check9("estop_resume", obs(), {2'd0, 3'b100, 4'b0010});
    tick(); check9("estop_last",   obs(), {2'd0, 3'b100, 4'b0010});
    tick(); check9("estop_arrive", obs(), {2'd1, 3'b001, 4'b0000});
`else
    tick(); check9("estop_ignored", obs(), {2'd0, 3'b100, 4'b0010});
    tick(); check9("estop_arrive",  obs(), {2'd1, 3'b001, 4'b0000});
    bus.estop = 1'b0;
`endif

    // Random requests, estop episodes and occasional resets against the model.
    rst = 1'b1; bus.n_stage = 3'b000; bus.estop = 1'b0;
    tick();
    model_step(1'b1, 3'b000, 1'b0);
    check9("rand_reset", obs(), model_obs());
    es = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      r  = ($urandom_range(0, 599) == 0);
      ns = ($urandom_range(0, 5) == 0) ? {1'b1, 2'($urandom_range(0, 3))} : 3'b000;
      if ($urandom_range(0, 59) == 0) es = ~es;
      rst = r; bus.n_stage = ns; bus.estop = es;
      tick();
      model_step(r, ns, es);
      check9($sformatf("rand%0d", n), obs(), model_obs());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
